// File: rtl/alu_stimulus_gen_pkg.sv
// Shared types, constants and LFSR helpers for the ALU stimulus generator.
// The corner-vector table is only consumed when ALU_STIM_CORNER_EN is defined.
package alu_stim_pkg;

    localparam int unsigned OP_W     = 4;
    localparam int unsigned N_CORNER = 4;

    // Fibonacci taps 8,6,5,4 -> register bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Element i is corner pair i: (00,00) (FF,01) (7F,01) (80,80)
    localparam logic [N_CORNER-1:0][7:0] CORNER_A = {8'h80, 8'h7F, 8'hFF, 8'h00};
    localparam logic [N_CORNER-1:0][7:0] CORNER_B = {8'h80, 8'h01, 8'h01, 8'h00};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    // An all-zero seed would lock the LFSR up
    function automatic logic [7:0] lfsr8_seed(input logic [7:0] s);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

endpackage

// File: rtl/alu_stimulus_gen_if.sv
// Control/stimulus bundle between the stimulus generator (master) and its consumer (slave).
interface alu_stimulus_gen_if #(
    parameter int unsigned VEC_IDX_W = 5
);
    import alu_stim_pkg::*;

    logic                 start;
    logic                 pause;
    logic [7:0]           a;
    logic [7:0]           b;
    logic [OP_W-1:0]      ALUControl;
    logic                 vec_valid;
    logic [VEC_IDX_W-1:0] vec_index;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, pause,
        output a, b, ALUControl, vec_valid, vec_index, busy, done
    );

    modport slave (
        output start, pause,
        input  a, b, ALUControl, vec_valid, vec_index, busy, done
    );

endinterface

// File: rtl/alu_stimulus_gen_lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR with seed load and advance controls.
// Load together with advance yields the value following the seed in one edge.
module lfsr8
    import alu_stim_pkg::*;
#(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_load,
    input  logic       i_advance,
    output logic [7:0] o_q
);

    localparam logic [7:0] SEED_EFF = lfsr8_seed(SEED);

    logic [7:0] r_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= SEED_EFF;
        end else if (i_load) begin
            r_q <= i_advance ? lfsr8_next(SEED_EFF) : SEED_EFF;
        end else if (i_advance) begin
            r_q <= lfsr8_next(r_q);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/alu_stimulus_gen.sv
// Sweeps every ALU op code over LFSR operand pairs, holding each vector HOLD_CYCLES cycles.
// Define ALU_STIM_CORNER_EN to prefix each op code with four fixed corner operand pairs.
module alu_stimulus_gen
    import alu_stim_pkg::*;
#(
    parameter int unsigned OP_COUNT       = 10,
    parameter int unsigned VECTORS_PER_OP = 16,
    parameter int unsigned HOLD_CYCLES    = 2,
    parameter logic [7:0]  SEED_A         = 8'hA5,
    parameter logic [7:0]  SEED_B         = 8'h3C
) (
    input  logic               clock,
    input  logic               reset,
    alu_stimulus_gen_if.master stim
);

    localparam int unsigned VIW = $clog2(VECTORS_PER_OP + 4);
    localparam int unsigned HW  = $clog2(HOLD_CYCLES);
`ifdef ALU_STIM_CORNER_EN
    localparam int unsigned PER_OP = VECTORS_PER_OP + N_CORNER;
`else
    localparam int unsigned PER_OP = VECTORS_PER_OP;
`endif
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [VIW-1:0]  VEC_LAST  = VIW'(PER_OP - 1);
    localparam logic [OP_W-1:0] OP_LAST   = OP_W'(OP_COUNT - 1);

    state_t          r_state, w_state_nxt;
    logic [HW-1:0]   r_hold, w_hold_nxt;
    logic [VIW-1:0]  r_vec_index, w_idx_nxt;
    logic [OP_W-1:0] r_op, w_op_nxt;
    logic [7:0]      r_a, r_b, w_a_nxt, w_b_nxt;
    logic            r_vec_valid, r_busy, r_done;
    logic            w_start_go, w_vec_end, w_op_end, w_sweep_end;
    logic            w_issue, w_lfsr_load, w_lfsr_adv;
    logic [7:0]      w_q_a, w_q_b, w_lfsr_a, w_lfsr_b;

    lfsr8 #(.SEED(SEED_A)) u_lfsr_a (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_lfsr_load),
        .i_advance (w_lfsr_adv),
        .o_q       (w_q_a)
    );

    lfsr8 #(.SEED(SEED_B)) u_lfsr_b (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_lfsr_load),
        .i_advance (w_lfsr_adv),
        .o_q       (w_q_b)
    );

    assign w_start_go  = (r_state != RUN) && stim.start;
    assign w_vec_end   = (r_state == RUN) && !stim.pause && (r_hold == HOLD_LAST);
    assign w_op_end    = w_vec_end && (r_vec_index == VEC_LAST);
    assign w_sweep_end = w_op_end && (r_op == OP_LAST);
    // The LFSR is still reloading on the start edge, so take the seed directly
    assign w_lfsr_a    = w_start_go ? lfsr8_seed(SEED_A) : w_q_a;
    assign w_lfsr_b    = w_start_go ? lfsr8_seed(SEED_B) : w_q_b;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, DONE: if (stim.start) w_state_nxt = RUN;
            RUN:        if (w_sweep_end) w_state_nxt = DONE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_issue     = 1'b0;
        w_lfsr_load = w_start_go;
        w_lfsr_adv  = 1'b0;
        w_idx_nxt   = r_vec_index;
        w_op_nxt    = r_op;
        w_hold_nxt  = r_hold;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;

        if (w_start_go) begin
            w_issue   = 1'b1;
            w_idx_nxt = '0;
            w_op_nxt  = '0;
        end else if (w_vec_end && !w_sweep_end) begin
            w_issue   = 1'b1;
            w_idx_nxt = w_op_end ? '0 : r_vec_index + 1'b1;
            w_op_nxt  = w_op_end ? r_op + 1'b1 : r_op;
        end else if (w_sweep_end) begin
            w_hold_nxt = '0;
        end else if ((r_state == RUN) && !stim.pause) begin
            w_hold_nxt = r_hold + 1'b1;
        end

        if (w_issue) begin
            w_hold_nxt = '0;
`ifdef ALU_STIM_CORNER_EN
            if (w_idx_nxt < VIW'(N_CORNER)) begin
                w_a_nxt = CORNER_A[w_idx_nxt[1:0]];
                w_b_nxt = CORNER_B[w_idx_nxt[1:0]];
            end else begin
                w_lfsr_adv = 1'b1;
                w_a_nxt    = w_lfsr_a;
                w_b_nxt    = w_lfsr_b;
            end
`else
            w_lfsr_adv = 1'b1;
            w_a_nxt    = w_lfsr_a;
            w_b_nxt    = w_lfsr_b;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_vec_index <= '0;
            r_hold      <= '0;
            r_vec_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_op        <= w_op_nxt;
            r_vec_index <= w_idx_nxt;
            r_hold      <= w_hold_nxt;
            r_vec_valid <= (w_state_nxt == RUN) && (w_hold_nxt == HOLD_LAST);
            r_busy      <= (w_state_nxt == RUN);
            r_done      <= (w_state_nxt == DONE);
        end
    end

    // Frozen state keeps the hold-phase flag, so masking here lets a vector paused
    // on its final hold cycle still report valid once released
    assign stim.vec_valid  = r_vec_valid & ~stim.pause;
    assign stim.a          = r_a;
    assign stim.b          = r_b;
    assign stim.ALUControl = r_op;
    assign stim.vec_index  = r_vec_index;
    assign stim.busy       = r_busy;
    assign stim.done       = r_done;

endmodule

// File: tb/tb_alu_stimulus_gen.sv
// Self-checking bench for alu_stimulus_gen: scoreboard of expected vectors per sweep.
// Builds with or without ALU_STIM_CORNER_EN.
module tb_alu_stimulus_gen;

    localparam int unsigned OPS    = 10;
    localparam int unsigned VPO    = 16;
    localparam int unsigned HOLD   = 2;
`ifdef ALU_STIM_CORNER_EN
    localparam int unsigned NC     = 4;
    localparam logic [7:0]  V0A = 8'h00, V0B = 8'h00, V1A = 8'hFF, V1B = 8'h01;
`else
    localparam int unsigned NC     = 0;
    localparam logic [7:0]  V0A = 8'hA5, V0B = 8'h3C, V1A = 8'h4A, V1B = 8'h79;
`endif
    localparam int unsigned PER_OP = VPO + NC;
    localparam int unsigned SWEEP  = OPS * PER_OP * HOLD;
    localparam int unsigned VIW    = $clog2(VPO + 4);
    localparam int unsigned BUDGET = 3000;

    typedef struct packed {
        logic [7:0]     a;
        logic [7:0]     b;
        logic [3:0]     op;
        logic [VIW-1:0] idx;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    alu_stimulus_gen_if #(.VEC_IDX_W(VIW)) bus ();

    alu_stimulus_gen #(
        .OP_COUNT       (OPS),
        .VECTORS_PER_OP (VPO),
        .HOLD_CYCLES    (HOLD),
        .SEED_A         (8'hA5),
        .SEED_B         (8'h3C)
    ) dut (
        .clock (clock),
        .reset (reset),
        .stim  (bus)
    );

    vec_t sb_q[$];
    vec_t last_vec;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    function automatic logic [7:0] ref_lfsr(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic logic [15:0] corner_pair(input int unsigned i);
        case (i)
            0:       return 16'h0000;
            1:       return 16'hFF01;
            2:       return 16'h7F01;
            default: return 16'h8080;
        endcase
    endfunction

    function automatic vec_t sample_vec();
        return {bus.a, bus.b, bus.ALUControl, bus.vec_index};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_sweep();
        logic [7:0]  la, lb;
        logic [15:0] cp;
        vec_t v;
        la = 8'hA5;
        lb = 8'h3C;
        sb_q.delete();
        for (int unsigned op = 0; op < OPS; op++) begin
            for (int unsigned i = 0; i < PER_OP; i++) begin
                v.op  = 4'(op);
                v.idx = VIW'(i);
                if (i < NC) begin
                    cp  = corner_pair(i);
                    v.a = cp[15:8];
                    v.b = cp[7:0];
                end else begin
                    v.a = la;
                    v.b = lb;
                    la  = ref_lfsr(la);
                    lb  = ref_lfsr(lb);
                end
                sb_q.push_back(v);
            end
        end
    endtask

    task automatic do_start();
        push_sweep();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_and_score(input int unsigned pause_at, input int unsigned pause_len,
                                 input int unsigned start_at, input int unsigned reset_at,
                                 output int unsigned busy_cycles, output bit done_seen);
        vec_t got, exp, snap;
        snap        = '0;
        busy_cycles = 0;
        done_seen   = 1'b0;
        for (int unsigned k = 1; k <= BUDGET; k++) begin
            got = sample_vec();
            if (bus.busy) busy_cycles++;
            if (bus.vec_valid) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL scoreboard_extra: vec_valid with empty queue at k=%0d got %h", k, got);
                end else begin
                    exp      = sb_q.pop_front();
                    last_vec = exp;
                    if (got !== exp) begin
                        n_errors++;
                        $display("FAIL scoreboard: k=%0d got a=%h b=%h op=%0d idx=%0d expected a=%h b=%h op=%0d idx=%0d",
                                 k, got.a, got.b, got.op, got.idx, exp.a, exp.b, exp.op, exp.idx);
                    end
                end
            end
            if (pause_at != 0 && k > pause_at && k <= pause_at + pause_len) begin
                n_checks++;
                if (got !== snap || bus.vec_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL pause_freeze: k=%0d got %h valid=%b expected %h valid=0",
                             k, got, bus.vec_valid, snap);
                end
                if (k == pause_at + pause_len) bus.pause = 1'b0;
            end
            if (k == pause_at) begin
                snap      = got;
                bus.pause = 1'b1;
            end
            if (start_at != 0 && k == start_at + 1) bus.start = 1'b0;
            if (k == start_at) bus.start = 1'b1;
            if (k == reset_at) begin
                reset = 1'b1;
                tick();
                return;
            end
            if (bus.done) begin
                done_seen = 1'b1;
                break;
            end
            tick();
        end
        if (!done_seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: done not seen within %0d cycles", BUDGET);
        end
    endtask

    task automatic check_idle_zero(input string name);
        n_checks++;
        if ({bus.a, bus.b, bus.ALUControl, bus.vec_index, bus.vec_valid, bus.busy, bus.done} !== '0) begin
            n_errors++;
            $display("FAIL %s: got a=%h b=%h op=%h idx=%h valid=%b busy=%b done=%b expected all 0",
                     name, bus.a, bus.b, bus.ALUControl, bus.vec_index, bus.vec_valid, bus.busy, bus.done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        check_idle_zero("reset_state");
        reset = 1'b0;
        tick();
        check_idle_zero("idle_after_reset");
    endtask

    task automatic test_first_vectors();
        do_start();
        n_checks++;
        if (bus.a !== V0A || bus.b !== V0B || bus.ALUControl !== 4'd0 || bus.busy !== 1'b1 || bus.vec_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL first_vector: got a=%h b=%h op=%h busy=%b valid=%b expected a=%h b=%h op=0 busy=1 valid=0",
                     bus.a, bus.b, bus.ALUControl, bus.busy, bus.vec_valid, V0A, V0B);
        end
        tick();
        n_checks++;
        if (bus.vec_valid !== 1'b1 || bus.a !== V0A) begin
            n_errors++;
            $display("FAIL first_valid: got valid=%b a=%h expected valid=1 a=%h", bus.vec_valid, bus.a, V0A);
        end
        tick();
        n_checks++;
        if (bus.a !== V1A || bus.b !== V1B || bus.vec_index !== VIW'(1) || bus.vec_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL second_vector: got a=%h b=%h idx=%0d valid=%b expected a=%h b=%h idx=1 valid=0",
                     bus.a, bus.b, bus.vec_index, bus.vec_valid, V1A, V1B);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_zero("reset_after_first");
    endtask

    task automatic check_sweep_end(input string name, input int unsigned busy_cycles,
                                   input int unsigned expected_busy);
        n_checks++;
        if (busy_cycles !== expected_busy) begin
            n_errors++;
            $display("FAIL %s_busy_len: got %0d expected %0d", name, busy_cycles, expected_busy);
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_queue_drain: got %0d leftover expected 0", name, sb_q.size());
        end
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_done_flags: got done=%b busy=%b expected done=1 busy=0", name, bus.done, bus.busy);
        end
    endtask

    task automatic test_full_sweep();
        int unsigned bc;
        bit ds;
        do_start();
        run_and_score(0, 0, 0, 0, bc, ds);
        check_sweep_end("full", bc, SWEEP);
        repeat (3) tick();
        n_checks++;
        if (bus.a !== last_vec.a || bus.b !== last_vec.b || bus.ALUControl !== last_vec.op ||
            bus.done !== 1'b1 || bus.vec_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL done_hold: got a=%h b=%h op=%h done=%b valid=%b expected a=%h b=%h op=%h done=1 valid=0",
                     bus.a, bus.b, bus.ALUControl, bus.done, bus.vec_valid, last_vec.a, last_vec.b, last_vec.op);
        end
    endtask

    task automatic test_pause();
        int unsigned bc;
        bit ds;
        do_start();
        n_checks++;
        if (bus.done !== 1'b0 || bus.a !== V0A) begin
            n_errors++;
            $display("FAIL restart_from_done: got done=%b a=%h expected done=0 a=%h", bus.done, bus.a, V0A);
        end
        run_and_score(51, 5, 0, 0, bc, ds);
        check_sweep_end("pause", bc, SWEEP + 5);
    endtask

    task automatic test_start_in_run();
        int unsigned bc;
        bit ds;
        do_start();
        run_and_score(0, 0, 77, 0, bc, ds);
        check_sweep_end("start_ignored", bc, SWEEP);
    endtask

    task automatic test_done_behaviour();
        bus.pause = 1'b1;
        repeat (4) tick();
        bus.pause = 1'b0;
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.a !== last_vec.a) begin
            n_errors++;
            $display("FAIL pause_in_done: got done=%b busy=%b a=%h expected done=1 busy=0 a=%h",
                     bus.done, bus.busy, bus.a, last_vec.a);
        end
        do_start();
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.a !== V0A || bus.b !== V0B || bus.ALUControl !== 4'd0) begin
            n_errors++;
            $display("FAIL done_restart: got done=%b busy=%b a=%h b=%h op=%h expected done=0 busy=1 a=%h b=%h op=0",
                     bus.done, bus.busy, bus.a, bus.b, bus.ALUControl, V0A, V0B);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int unsigned bc;
        bit ds;
        do_start();
        run_and_score(0, 0, 0, 100, bc, ds);
        check_idle_zero("mid_sweep_reset");
        reset = 1'b0;
        repeat (5) tick();
        check_idle_zero("stays_idle");
        do_start();
        run_and_score(0, 0, 0, 0, bc, ds);
        check_sweep_end("after_reset", bc, SWEEP);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.pause = 1'b0;
        test_reset();
        test_first_vectors();
        test_full_sweep();
        test_pause();
        test_start_in_run();
        test_done_behaviour();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
